// File: rtl/eth_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// eth_tx_arbiter_pkg
// Shared types and helpers for the Ethernet TX packet arbiter.
//   state_t     : arbiter FSM state (IDLE, PASS)
//   keep_width  : tkeep width for a given tdata width (one bit per byte)
//   MAX_PORTS   : largest supported number of upstream requesters
// ---------------------------------------------------------------------------
package eth_tx_arbiter_pkg;

    localparam int MAX_PORTS = 8;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } state_t;

    function automatic int keep_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/eth_tx_arbiter_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Purely combinational round-robin picker: returns the lowest requesting
// index at or above ptr_i, wrapping to the lowest requesting index overall
// when nothing at or above the pointer is requesting.
// Ports:
//   req_i  : one request bit per port
//   ptr_i  : index holding highest priority this round
//   any_o  : at least one request is present
//   idx_o  : chosen index (0 when any_o is low)
// ---------------------------------------------------------------------------
module rr_priority_pick #(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]         req_i,
    input  logic [$clog2(NUM_PORTS)-1:0] ptr_i,
    output logic                         any_o,
    output logic [$clog2(NUM_PORTS)-1:0] idx_o
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    logic             found_hi;
    logic [IDX_W-1:0] idx_hi;
    logic [IDX_W-1:0] idx_lo;

    // Scanning downwards leaves the lowest matching index in each candidate.
    always_comb begin
        found_hi = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (req_i[p]) begin
                idx_lo = IDX_W'(p);
                if (IDX_W'(p) >= ptr_i) begin
                    idx_hi   = IDX_W'(p);
                    found_hi = 1'b1;
                end
            end
        end
        any_o = |req_i;
        idx_o = found_hi ? idx_hi : idx_lo;
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// ---------------------------------------------------------------------------
// eth_tx_arbiter
// Packet-level round-robin arbiter sharing the MAC/PCS TX AXI-Stream between
// NUM_PORTS upstream requesters. A grant is held from the first beat to the
// accepted tlast beat, so frames never interleave. One idle cycle separates
// consecutive frames (the MAC inserts IPG anyway).
// Ports:
//   i_clk, i_reset_n         : TX user clock, asynchronous active-low reset
//   s_axis_*                 : packed upstream streams, port p at slice p
//   m00_axis_*               : stream to the MAC s00_axis port
//   o_busy                   : a frame is currently granted
//   o_grant                  : current or most recent granted port
//   o_frame_count            : packed per-port completed-frame counters
// ---------------------------------------------------------------------------
module eth_tx_arbiter
    import eth_tx_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                              i_clk,
    input  logic                              i_reset_n,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]              s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]              s_axis_tlast,
    output logic [NUM_PORTS-1:0]              s_axis_tready,
    output logic [DATA_WIDTH-1:0]             m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]           m00_axis_tkeep,
    output logic                              m00_axis_tvalid,
    output logic                              m00_axis_tlast,
    input  logic                              m00_axis_tready,
    output logic                              o_busy,
    output logic [$clog2(NUM_PORTS)-1:0]      o_grant,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]    o_frame_count
);

    localparam int KEEP_W = keep_width(DATA_WIDTH);
    localparam int IDX_W  = $clog2(NUM_PORTS);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [CNT_WIDTH-1:0] cnt_q [NUM_PORTS];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_PORTS];

    logic                  pick_any;
    logic [IDX_W-1:0]      pick_idx;
    logic [DATA_WIDTH-1:0] sel_tdata;
    logic [KEEP_W-1:0]     sel_tkeep;
    logic                  sel_tvalid;
    logic                  sel_tlast;
    logic                  frame_done;

    rr_priority_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .req_i (s_axis_tvalid),
        .ptr_i (rr_ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    // Granted-port stream mux.
    always_comb begin
        sel_tdata  = '0;
        sel_tkeep  = '0;
        sel_tvalid = 1'b0;
        sel_tlast  = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_q == IDX_W'(p)) begin
                sel_tdata  = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
                sel_tkeep  = s_axis_tkeep[p*KEEP_W +: KEEP_W];
                sel_tvalid = s_axis_tvalid[p];
                sel_tlast  = s_axis_tlast[p];
            end
        end
    end

    // FSM next state and outputs. IDLE drives a fully quiet bus; PASS is a
    // straight combinational connection of the granted port to the MAC.
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        grant_d         = grant_q;
        frame_done      = 1'b0;
        s_axis_tready   = '0;
        m00_axis_tdata  = '0;
        m00_axis_tkeep  = '0;
        m00_axis_tvalid = 1'b0;
        m00_axis_tlast  = 1'b0;
        o_busy          = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = PASS;
                end
            end
            PASS: begin
                m00_axis_tdata         = sel_tdata;
                m00_axis_tkeep         = sel_tkeep;
                m00_axis_tvalid        = sel_tvalid;
                m00_axis_tlast         = sel_tlast;
                s_axis_tready[grant_q] = m00_axis_tready;
                o_busy                 = 1'b1;
                if (sel_tvalid && m00_axis_tready && sel_tlast) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                    // The port that just sent drops to lowest priority.
                    rr_ptr_d   = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0
                                                                    : grant_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-port counters wrap naturally at 2^CNT_WIDTH.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            cnt_d[p] = cnt_q[p];
            if (frame_done && (grant_q == IDX_W'(p))) begin
                cnt_d[p] = cnt_q[p] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            for (int p = 0; p < NUM_PORTS; p++) begin
                cnt_q[p] <= cnt_d[p];
            end
        end
    end

    assign o_grant = grant_q;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt_out
        assign o_frame_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
    end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Packet-level round-robin arbiter sharing the single MAC/PCS transmit AXI-Stream (32-bit data, 4-bit tkeep) between NUM_PORTS upstream requesters, such as a host DMA path and a low-latency fabric path.
- Sits in the transceiver TX user-clock domain, directly in front of the mac_pcs s00_axis port.
- A grant is held from the first accepted beat to the accepted tlast beat, so frames are never interleaved.
- Per-port frame counters are provided for link bring-up and debug.

Parameters:
- NUM_PORTS, 4, number of upstream AXIS requesters (2..8).
- DATA_WIDTH, 32, tdata width; tkeep width is DATA_WIDTH/8.
- CNT_WIDTH, 16, width of each per-port sent-frame counter.

Ports:
- i_clk  in  1  TX user clock (connected to s00_axis_aclk of the MAC).
- i_reset_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  packed input data, port p at [p*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tkeep  in  NUM_PORTS*DATA_WIDTH/8  packed input keep.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tlast  in  NUM_PORTS  per-port last.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- m00_axis_tdata  out  DATA_WIDTH  to MAC.
- m00_axis_tkeep  out  DATA_WIDTH/8  to MAC.
- m00_axis_tvalid  out  1  to MAC.
- m00_axis_tlast  out  1  to MAC.
- m00_axis_tready  in  1  from MAC.
- o_busy  out  1  high while a frame is granted.
- o_grant  out  $clog2(NUM_PORTS)  index of the current or most recent grant.
- o_frame_count  out  NUM_PORTS*CNT_WIDTH  packed per-port count of completed frames.

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled by the caller):
  - state=IDLE, rr_ptr=0, o_grant=0, o_busy=0, all counters=0.
  - s_axis_tready=0, m00_axis_tvalid=0, and m00 data/keep/last=0.
- States:
  - IDLE: outputs are idle (m00_axis_tvalid=0, all s_axis_tready=0). If any s_axis_tvalid is set, choose the lowest valid index p >= rr_ptr, wrapping modulo NUM_PORTS. Register o_grant=p, go to PASS next cycle. Arbitration latency is 1 cycle.
  - PASS: the m00 outputs are combinationally the granted port's tdata/tkeep/tvalid/tlast.
    - s_axis_tready[o_grant]=m00_axis_tready; all other tready bits are 0.
    - o_busy=1.
    - On an accepted beat (valid && ready) with tlast: increment the granted port's counter (wraps at 2^CNT_WIDTH), set rr_ptr=(o_grant+1) mod NUM_PORTS, return to IDLE.
- Inter-frame gap: there is exactly one idle cycle between back-to-back frames, including frames from the same port. This is acceptable because the MAC inserts IPG anyway.
- Fairness: a port that sends a frame loses priority to every other requesting port. Port 0 is highest priority after reset.
- Grant-time rules:
  - Valid deasserting mid-frame on the granted port is passed through unchanged. The grant is held and no re-arbitration occurs. Underrun handling is upstream's responsibility.
  - Requests from non-granted ports are ignored until the next IDLE and never see tready.
- Timing of inputs:
  - A valid rising in the same cycle the FSM leaves PASS is considered only in the following IDLE cycle.
  - Valid on the non-chosen ports in IDLE has no effect beyond arbitration.
- A single-beat frame (tvalid && tlast on the first beat) is one PASS cycle when ready is high, and the counter increments.
- Reset asserted mid-frame: the FSM returns immediately to IDLE with all tready=0. The partial frame is truncated; the MAC/PCS is reset by the same condition.
- o_grant holds its value in IDLE until the next arbitration.

Decomposition:
- Package eth_tx_arbiter_pkg:
  - state enum (IDLE, PASS);
  - function keep_width(DATA_WIDTH);
  - constant MAX_PORTS=8.
- Sub-module rr_priority_pick: purely combinational, inputs req[NUM_PORTS] and ptr, outputs any and idx. It can be reused later for an RX-side fan-out scheduler.

Test Plan:
1. Reset then idle: hold i_reset_n=0 for 5 cycles with all ports valid → m00_axis_tvalid=0, s_axis_tready=0, counters=0. Release → o_grant=0 two cycles later and port 0's first beat appears on m00.
2. Round-robin: ports 0..3 each continuously offer 3-beat frames with m00_axis_tready=1 → output order 0,1,2,3,0, each frame 3 contiguous beats with 1 idle cycle between. o_frame_count=1,1,1,1 after the first round.
3. Backpressure: port 2 sends a 4-beat frame while m00_axis_tready toggles 1,0,1,0 → data stable while stalled, s_axis_tready[2] mirrors m00_axis_tready, other ports' tready=0 throughout.
4. Mid-frame valid gap: port 1 deasserts tvalid for 2 cycles in beat 2 while port 3 requests → grant stays 1, m00_axis_tvalid=0 for those 2 cycles, port 3 is served only after port 1's tlast.
5. Single-beat frames and wrap: NUM_PORTS=4 and CNT_WIDTH=4; port 3 alone sends 17 single-beat frames → each takes 2 cycles (IDLE+PASS), final count=1, rr_ptr always wraps to 0.
6. Reset mid-frame: assert i_reset_n=0 on beat 2 of a 5-beat frame → tready and m00_axis_tvalid drop in the same cycle (asynchronous), and the FSM is in IDLE with o_busy=0 after release.
